// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Optional hit/miss/writeback counters are compiled in with `define CACHE_STATS_EN.
module dm_cache_ctrl #(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses,
  output logic [31:0]   stat_wbacks
`endif
);

  localparam int unsigned IDX = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG = 28 - IDX;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e                state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG-1:0]        tag_q  [NUM_BLOCKS];
  logic [TAG-1:0]        tag_d  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];
  logic [127:0]          data_d [NUM_BLOCKS];
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [27:0]           mem_addr_q, mem_addr_d;
  logic [127:0]          mem_wdata_q, mem_wdata_d;

  logic [1:0]            req_off;
  logic [IDX-1:0]        req_idx;
  logic [TAG-1:0]        req_tag;
  logic                  req, hit;

  assign req_off = proc_addr[1:0];
  assign req_idx = proc_addr[IDX+1:2];
  assign req_tag = proc_addr[29:IDX+2];
  assign req     = proc_read | proc_write;
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Core-facing handshake: stall and read data resolve in the request cycle
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    if (!rst) begin
      if (state_q != COMPARE) begin
        proc_stall = 1'b1;
      end else if (req && !hit) begin
        proc_stall = 1'b1;
      end else if (proc_read && !proc_write && hit) begin
        proc_rdata = data_q[req_idx][{req_off, 5'd0} +: 32];
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic        refill_q, refill_d;
  logic [31:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;
  logic [31:0] stat_wbacks_q, stat_wbacks_d;

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
  assign stat_wbacks = stat_wbacks_q;

  // Saturating counters; the re-compare after a fill is not a fresh hit
  always_comb begin
    refill_d      = refill_q;
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    stat_wbacks_d = stat_wbacks_q;
    case (state_q)
      COMPARE: begin
        refill_d = 1'b0;
        if (req && hit && !refill_q && (stat_hits_q != '1)) stat_hits_d = stat_hits_q + 32'd1;
        if (req && !hit && (stat_misses_q != '1)) stat_misses_d = stat_misses_q + 32'd1;
      end
      WRITEBACK: begin
        if (mem_ready && (stat_wbacks_q != '1)) stat_wbacks_d = stat_wbacks_q + 32'd1;
      end
      ALLOCATE: begin
        if (mem_ready) refill_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q      <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
      stat_wbacks_q <= '0;
    end else begin
      refill_q      <= refill_d;
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
      stat_wbacks_q <= stat_wbacks_d;
    end
  end
`endif

  // Next-state, line update and memory-side request decode
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      COMPARE: begin
        if (req && hit) begin
          if (proc_write) begin
            data_d[req_idx][{req_off, 5'd0} +: 32] = proc_wdata;
            dirty_d[req_idx] = 1'b1;
          end
        end else if (req) begin
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[req_idx], req_idx};
            mem_wdata_d = data_q[req_idx];
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = {req_tag, req_idx};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d          = ALLOCATE;
          dirty_d[req_idx] = 1'b0;
          mem_write_d      = 1'b0;
          mem_wdata_d      = '0;
          mem_read_d       = 1'b1;
          mem_addr_d       = {req_tag, req_idx};
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          state_d          = COMPARE;
          data_d[req_idx]  = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          mem_read_d       = 1'b0;
          mem_addr_d       = '0;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMPARE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed plan steps, then random traffic
// against a word-level memory image and a per-index line-occupancy model.
module tb_dm_cache_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          proc_read, proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata, proc_rdata;
  logic          proc_stall, mem_read, mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata, mem_rdata;
  logic          mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_wbacks;
`endif

  dm_cache_ctrl #(.NUM_BLOCKS(8)) dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Memory image: backing store by line, core-visible writes by word
  logic [127:0] store [logic [27:0]];
  logic [31:0]  refm  [logic [29:0]];
  // Which line each index currently holds, per the cache rules
  logic [7:0]   mv, md;
  logic [24:0]  mt [8];

  logic [31:0]  last_rdata;
  int           last_stalls;
  logic [27:0]  cap_wb_addr, cap_rd_addr;
  logic [127:0] cap_wb_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] init_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = {la, 2'(w), 2'b01};
    return l;
  endfunction

  function automatic logic [127:0] store_line(input logic [27:0] la);
    if (store.exists(la)) return store[la];
    return init_line(la);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    logic [127:0] l;
    if (refm.exists(a)) return refm[a];
    l = store_line(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_word({la, 2'(w)});
    return l;
  endfunction

  // Reset loses dirty lines: fall back to what memory holds
  task automatic model_reset();
    for (int i = 0; i < 8; i++)
      if (mv[i] && md[i])
        for (int w = 0; w < 4; w++) refm.delete({mt[i], 3'(i), 2'(w)});
    mv = '0;
    md = '0;
  endtask

  // One core request, serviced to completion; memory latencies in wait cycles
  task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                        input logic [31:0] wd, input int wlat, input int rlat);
    logic [2:0]  idx;
    logic [24:0] tag;
    logic        exp_hit, exp_wb, saw_wb, saw_rd, done;
    logic [27:0] vla;
    int          stalls, wseen, rseen, exp_st;
    idx = addr[4:2];
    tag = addr[29:5];
    exp_hit = mv[idx] && (mt[idx] == tag);
    exp_wb  = !exp_hit && mv[idx] && md[idx];
    vla = {mt[idx], idx};
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
    stalls = 0; wseen = 0; rseen = 0; saw_wb = 0; saw_rd = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!proc_stall) begin
        done = 1;
        last_rdata = proc_rdata;
        if (rd && !wr) check("rdata", 128'(proc_rdata), 128'(ref_word(addr)));
      end else begin
        stalls++;
        if (mem_write) begin
          if (wseen == 0) begin
            check("wb_addr", 128'(mem_addr), 128'(vla));
            check("wb_data", mem_wdata, ref_line(vla));
            cap_wb_addr = mem_addr;
            cap_wb_data = mem_wdata;
          end
          wseen++;
          saw_wb = 1;
          if (wseen == wlat + 1) begin
            mem_ready = 1'b1;
            store[mem_addr] = mem_wdata;
          end
        end else if (mem_read) begin
          if (rseen == 0) begin
            check("fill_addr", 128'(mem_addr), 128'({tag, idx}));
            cap_rd_addr = mem_addr;
          end
          rseen++;
          saw_rd = 1;
          if (rseen == rlat + 1) begin
            mem_ready = 1'b1;
            mem_rdata = store_line(mem_addr);
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {4{$urandom}};
    end
    check("timeout", 128'(done), 128'd1);
    exp_st = exp_hit ? 0 : 1 + (exp_wb ? wlat + 1 : 0) + rlat + 1;
    check("stall_cycles", 128'(stalls), 128'(exp_st));
    check("wb_seen", 128'(saw_wb), 128'(exp_wb));
    check("fill_seen", 128'(saw_rd), 128'(!exp_hit));
    last_stalls = stalls;
    if (!exp_hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tag;
      md[idx] = 1'b0;
    end
    if (wr) begin
      refm[addr] = wd;
      md[idx] = 1'b1;
    end
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask

  // No request: no stall, no traffic, stray mem_ready must be ignored
  task automatic idle_cycle();
    proc_read = 1'b0;
    proc_write = 1'b0;
    #1;
    check("idle_stall", 128'(proc_stall), 128'd0);
    check("idle_traffic", 128'({mem_read, mem_write}), 128'd0);
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [29:0] a;
    int          rseen;
    rst = 1'b1;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    mv = '0; md = '0;
    for (int i = 0; i < 8; i++) mt[i] = '0;
    store[28'h1] = 128'h44444444_33333333_22222222_11111111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 128'(proc_stall), 128'd0);
    check("rst_rdata", 128'(proc_rdata), 128'd0);
    check("rst_mem_rw", 128'({mem_read, mem_write}), 128'd0);
    check("rst_mem_addr", 128'(mem_addr), 128'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
`ifdef CACHE_STATS_EN
    check("rst_stats", 128'({stat_hits, stat_misses, stat_wbacks}), 128'd0);
`endif

    // Clean miss with 3 wait cycles, then hits on the same line
    access(1'b1, 1'b0, 30'h4, 32'h0, 0, 3);
    check("miss_fill_addr", 128'(cap_rd_addr), 128'h1);
    check("miss_rdata", 128'(last_rdata), 128'h11111111);
    check("miss_stalls", 128'(last_stalls), 128'd5);
    access(1'b1, 1'b0, 30'h5, 32'h0, 0, 0);
    check("hit_rdata", 128'(last_rdata), 128'h22222222);
    access(1'b0, 1'b1, 30'h6, 32'hDEADBEEF, 0, 0);
    access(1'b1, 1'b0, 30'h6, 32'h0, 0, 0);
    check("write_hit_rdata", 128'(last_rdata), 128'hDEADBEEF);

    // Conflict on index 1 with a dirty victim
    access(1'b1, 1'b0, 30'h24, 32'h0, 2, 1);
    check("dirty_wb_addr", 128'(cap_wb_addr), 128'h1);
    check("dirty_wb_data", cap_wb_data, 128'h44444444_DEADBEEF_22222222_11111111);
    check("dirty_fill_addr", 128'(cap_rd_addr), 128'h9);
`ifdef CACHE_STATS_EN
    check("stat_hits", 128'(stat_hits), 128'd3);
    check("stat_misses", 128'(stat_misses), 128'd2);
    check("stat_wbacks", 128'(stat_wbacks), 128'd1);
`endif

    // Reset during ALLOCATE abandons the fill
    proc_read = 1'b1;
    proc_addr = 30'h4;
    rseen = 0;
    for (int c = 0; c < 50 && rseen < 2; c++) begin
      #1;
      if (mem_read) rseen++;
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_fill", 128'(rseen), 128'd2);
    rst = 1'b1;
    proc_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_mem_read", 128'(mem_read), 128'd0);
    check("mid_rst_mem_write", 128'(mem_write), 128'd0);
    check("mid_rst_stall", 128'(proc_stall), 128'd0);
    model_reset();
    access(1'b1, 1'b0, 30'h4, 32'h0, 0, 2);
    check("post_rst_rdata", 128'(last_rdata), 128'h11111111);

    // Random traffic over 4 tags x 8 indices
    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = 30'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if (kind == 0)      idle_cycle();
      else if (kind <= 5) access(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 4), $urandom_range(0, 4));
      else if (kind <= 8) access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
      else                access(1'b1, 1'b1, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
